gerador_acorde: RTL
===================

// Module: gerador_acorde
// PURPOSE
//  Transmitter side of the note-entry protocol: plays a chord sequence into the chord identifier.
//  Given a chord type, two root notes and a variant bit, it drives nota[3:0] and strobes ok once per note.
//  The sequence is exactly what the identifier needs to reach that type's final state.
//  Used as a stimulus/playback source in front of the identifier.
// PARAMETERS
//  SETUP    2  cycles nota is stable before ok rises (>=1)
//  PULSE_W  2  cycles ok is held high (>=1)
//  GAP      2  cycles ok is low, nota still held, before next note (>=1)
// PORTS
//  clk       in   1  single clock; all logic on posedge clk
//  reset     in   1  synchronous, active-high reset
//  start     in   1  request a sequence; sampled only in IDLE
//  tipo      in   2  00 nenhum, 01 adj, 10 comp, 11 adv; captured at start
//  var_si    in   1  0: third note La_m (4'b1110); 1: Si_m (4'b1111); only for adj/comp; captured at start
//  nota1     in   4  first note; captured at start
//  nota2     in   4  second note; captured at start
//  nota      out  4  note presented to identifier
//  ok        out  1  strobe; identifier samples nota on its rising edge
//  busy      out  1  high from cycle after accepted start until done cycle inclusive
//  done      out  1  1-cycle pulse after last note's GAP
//  erro      out  1  1-cycle pulse: start rejected (invalid roots)
// BEHAVIOUR
//  Reset: nota=0, ok=0, busy=0, done=0, erro=0, FSM=IDLE. Reset mid-sequence aborts at once; nothing resumes.
//  Null note = 4'b0000 or 4'b1000. Terminator emitted is always 4'b0000.
//  Sequences, L = length:
//   adj  (01): nota1, nota2, T3, 0000                     L=4  (T3 = La_m/Si_m per var_si)
//   comp (10): nota1, nota2, T3, T4, 0000                 L=5  (T4 = Do 0001 if La_m, Re 0010 if Si_m)
//   adv  (11): nota1, nota2, La_m 1110, Si_m 1111, 0000   L=5  (var_si ignored)
//   nenhum (00): nota1, 0000                              L=2  (drives identifier to error state)
//  Validation, tipo!=00 only: if nota1 or nota2 is null, erro=1 the cycle after start, no strobes, stay IDLE.
//  FSM: IDLE -> SETUP -> STROBE -> GAP -> (SETUP next note | DONE) -> IDLE
//   - Start accepted at edge T0 (IDLE, start=1). Cycle T1: busy=1, nota=note0.
//   - Per note k (k=0..L-1), P = SETUP+PULSE_W+GAP:
//       nota=note_k during cycles T1+kP .. T1+(k+1)P-1
//       ok=1 during T1+kP+SETUP .. T1+kP+SETUP+PULSE_W-1
//   - done=1 at cycle T1+L*P; busy drops the following cycle; nota returns to 0 in IDLE.
//  nota changes only while ok=0 and never within SETUP cycles before an ok rise.
//  Exactly L ok rising edges per accepted sequence.
//  start while busy is ignored, not queued. start the cycle after done is accepted normally.
//  Phase counter ceil(log2(max(SETUP,PULSE_W,GAP)+1)) bits; note index 3 bits.
//  Inputs are captured at start; later changes have no effect on the running sequence.
// TESTING (defaults, P=6; T0 = start edge)
//  1. tipo=11, nota1=0001, nota2=0011, start -> nota 0001,0011,1110,1111,0000; ok high T3-4, T9-10, T15-16, T21-22, T27-28; done at T31.
//  2. tipo=10, var_si=1, nota1=0101, nota2=0111 -> 0101,0111,1111,0010,0000; identifier ends tipo=10, fim=1.
//  3. tipo=01, var_si=0, nota1=0010, nota2=0100 -> 4 strobes; done at T25; identifier tipo=01.
//  4. tipo=10, nota2=1000 -> erro=1 at T1, ok stays 0, busy stays 0; tipo=00 nota1=0011 -> 0011,0000; identifier fim=1, tipo=00.
//  5. reset=1 at T10 of case 1 -> next cycle ok=0, nota=0, busy=0; start re-pulsed during busy has no effect (count 5 ok edges).
//  6. Back-to-back: start held high through done -> second sequence begins T1 after first returns IDLE; per-sequence ok edge count exact.

Source files
------------

// File: rtl/gerador_acorde_if.sv
// rtl/gerador_acorde_if.sv - note-entry playback bus between sequencer and its user
interface gerador_acorde_if;
  logic       start;
  logic [1:0] tipo;
  logic       var_si;
  logic [3:0] nota1;
  logic [3:0] nota2;
  logic [3:0] nota;
  logic       ok;
  logic       busy;
  logic       done;
  logic       erro;

  modport master (
    output start, tipo, var_si, nota1, nota2,
    input  nota, ok, busy, done, erro
  );

  modport slave (
    input  start, tipo, var_si, nota1, nota2,
    output nota, ok, busy, done, erro
  );
endinterface

// File: rtl/gerador_acorde.sv
// rtl/gerador_acorde.sv - plays a chord note sequence with setup/strobe/gap timing on ok
module gerador_acorde #(
  parameter int SETUP   = 2,
  parameter int PULSE_W = 2,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  gerador_acorde_if.slave   bus
);
  localparam int MAX_SP = (SETUP > PULSE_W) ? SETUP : PULSE_W;
  localparam int MAXP   = (MAX_SP > GAP) ? MAX_SP : GAP;
  localparam int PW     = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    tipo_q, tipo_d;
  logic          var_q, var_d;
  logic [3:0]    n1_q, n1_d;
  logic [3:0]    n2_q, n2_d;
  logic          erro_q, erro_d;
  logic [3:0]    note_cur;
  logic [2:0]    last_idx;
  logic          roots_bad;

  // Null notes are 0000 and 1000; only chord types other than nenhum need valid roots
  assign roots_bad = (bus.tipo != 2'b00) &&
                     ((bus.nota1[2:0] == 3'b000) || (bus.nota2[2:0] == 3'b000));

  always_comb begin
    last_idx = 3'd4;
    if (tipo_q == 2'b00) last_idx = 3'd1;
    else if (tipo_q == 2'b01) last_idx = 3'd3;
  end

  always_comb begin
    note_cur = 4'b0000;
    case (idx_q)
      3'd0: note_cur = n1_q;
      3'd1: note_cur = (tipo_q == 2'b00) ? 4'b0000 : n2_q;
      3'd2: note_cur = ((tipo_q != 2'b11) && var_q) ? 4'b1111 : 4'b1110;
      3'd3: begin
        if (tipo_q == 2'b10) note_cur = var_q ? 4'b0010 : 4'b0001;
        else if (tipo_q == 2'b11) note_cur = 4'b1111;
        else note_cur = 4'b0000;
      end
      default: note_cur = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    tipo_d  = tipo_q;
    var_d   = var_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    erro_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (roots_bad) begin
            erro_d = 1'b1;
          end else begin
            tipo_d  = bus.tipo;
            var_d   = bus.var_si;
            n1_d    = bus.nota1;
            n2_d    = bus.nota2;
            idx_d   = 3'd0;
            phase_d = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (phase_q == PW'(SETUP - 1)) begin
          phase_d = '0;
          state_d = S_STROBE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_STROBE: begin
        if (phase_q == PW'(PULSE_W - 1)) begin
          phase_d = '0;
          state_d = S_GAP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_GAP: begin
        if (phase_q == PW'(GAP - 1)) begin
          phase_d = '0;
          if (idx_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SETUP;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= 3'd0;
      tipo_q  <= 2'b00;
      var_q   <= 1'b0;
      n1_q    <= 4'b0000;
      n2_q    <= 4'b0000;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      tipo_q  <= tipo_d;
      var_q   <= var_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      erro_q  <= erro_d;
    end
  end

  // Outputs decode the registered state, so they never glitch between notes
  assign bus.busy = (state_q != S_IDLE);
  assign bus.ok   = (state_q == S_STROBE);
  assign bus.done = (state_q == S_DONE);
  assign bus.erro = erro_q;
  assign bus.nota = ((state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_GAP))
                    ? note_cur : 4'b0000;
endmodule
